// File: rtl/input_conditioner_pkg.sv
// Shared helpers for the input conditioner: counter-width derivation used by
// the prescaler and per-channel debounce counters.
package input_conditioner_pkg;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle of raw inputs and conditioned outputs between board pins and user logic.
interface input_conditioner_if #(
    parameter int WIDTH = 4
);
    // No handshake: out is a level, rise/fall/long_prs/tick are single-cycle
    // strobes qualified only by the clock, all driven from registers.
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] long_prs;
    logic             tick;

    modport master (
        output in,
        input  out,
        input  rise,
        input  fall,
        input  long_prs,
        input  tick
    );

    modport slave (
        input  in,
        output out,
        output rise,
        output fall,
        output long_prs,
        output tick
    );
endinterface

// File: rtl/input_conditioner_chan.sv
// One conditioner channel: synchroniser, tick-qualified debounce counter,
// edge strobes and optional long-press hold counter.
module input_conditioner_chan
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N           = 4,
    parameter int LONG_TICKS  = 0,
    parameter bit INV         = 1'b0,
    parameter bit INIT        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_out,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);
    localparam int            CW      = cnt_width(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_out;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_x;
    logic                   w_s;
    logic                   w_change;

    assign w_x      = i_raw ^ INV;
    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_change = i_tick && (w_s != r_out) && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{INIT}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_x};
        end
    end

    // Any agreeing tick clears the count, so only N disagreeing ticks in a row move out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_out  <= INIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_tick) begin
                if (w_s == r_out) begin
                    r_cnt <= '0;
                end else if (w_change) begin
                    r_out  <= w_s;
                    r_cnt  <= '0;
                    r_rise <= w_s;
                    r_fall <= ~w_s;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_out  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

    generate
        if (LONG_TICKS > 0) begin : g_long
            localparam int            HW        = $clog2(LONG_TICKS + 1);
            localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
            localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

            logic [HW-1:0] r_hold;
            logic          r_long;
            logic          w_out_nxt;

            // Clearing on the next out value lets the fall tick reset hold itself.
            assign w_out_nxt = r_out ^ w_change;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hold <= '0;
                    r_long <= 1'b0;
                end else begin
                    r_long <= 1'b0;
                    if (!w_out_nxt) begin
                        r_hold <= '0;
                    end else if (i_tick && r_out && (r_hold != HOLD_MAX)) begin
                        r_hold <= r_hold + HW'(1);
                        r_long <= (r_hold == HOLD_LAST);
                    end
                end
            end

            assign o_long = r_long;
        end else begin : g_no_long
            assign o_long = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: shared sample-tick prescaler feeding WIDTH
// independent synchronise/debounce/strobe channels.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               RATE        = 100000,
    parameter int               N           = 4,
    parameter int               LONG_TICKS  = 0,
    parameter logic [WIDTH-1:0] INVERT      = '0,
    parameter logic [WIDTH-1:0] INIT_VAL    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input_conditioner_if.slave   bus
);
    localparam int            PW       = cnt_width(RATE);
    localparam logic [PW-1:0] PCNT_MAX = PW'(RATE - 1);

    logic [PW-1:0]    r_pcnt;
    logic             r_tick;
    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_long;

    // tick is registered, so it lands one cycle after the prescaler reaches its top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pcnt == PCNT_MAX);
            r_pcnt <= (r_pcnt == PCNT_MAX) ? '0 : r_pcnt + PW'(1);
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            input_conditioner_chan #(
                .SYNC_STAGES(SYNC_STAGES),
                .N          (N),
                .LONG_TICKS (LONG_TICKS),
                .INV        (INVERT[i]),
                .INIT       (INIT_VAL[i])
            ) u_chan (
                .clk   (clk),
                .rst   (rst),
                .i_raw (bus.in[i]),
                .i_tick(r_tick),
                .o_out (w_out[i]),
                .o_rise(w_rise[i]),
                .o_fall(w_fall[i]),
                .o_long(w_long[i])
            );
        end
    endgenerate

    assign bus.out      = w_out;
    assign bus.rise     = w_rise;
    assign bus.fall     = w_fall;
    assign bus.long_prs = w_long;
    assign bus.tick     = r_tick;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: stimulus tasks push timestamped strobe
// events into a sorted queue, a negedge monitor pops and compares them.
module tb_input_conditioner;
    localparam int         WIDTH      = 4;
    localparam int         SYNC       = 2;
    localparam int         RATE       = 4;
    localparam int         N          = 3;
    localparam int         LONG_TICKS = 5;
    localparam logic [3:0] INVERT     = 4'b1000;
    localparam logic [3:0] INIT_VAL   = 4'b1000;
    localparam int         W          = 48;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;
    logic [3:0]   exp_out;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;

    input_conditioner_if #(.WIDTH(WIDTH)) bus ();

    input_conditioner #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC),
        .RATE       (RATE),
        .N          (N),
        .LONG_TICKS (LONG_TICKS),
        .INVERT     (INVERT),
        .INIT_VAL   (INIT_VAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset / cycle stamp ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Insert an expected event, keeping the queue ordered by cycle stamp.
    task automatic push(input logic [3:0] r, input logic [3:0] f, input logic [3:0] l,
                        input logic [3:0] o, input int t);
        logic [W-1:0] e;
        logic [W-1:0] tmp;
        int idx;
        e   = {r, f, l, o, 32'(t)};
        idx = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            tmp = exp_q[i];
            if (int'(tmp[31:0]) > t) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, e);
    endtask

    // First debounce evaluation edge that sees an input applied after edge c.
    function automatic int first_eval(input int c);
        int k;
        k = c + SYNC + 1;
        while (((k % RATE) != 1) || (k < RATE + 1)) k++;
        return k;
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic align();
        @(negedge clk);
        while ((cyc % RATE) != 1) @(negedge clk);
    endtask

    // Apply a raw input word right after a tick-phase edge and predict every strobe.
    task automatic apply(input logic [3:0] raw);
        int c;
        int t;
        logic [3:0] x;
        logic [3:0] r;
        logic [3:0] f;
        align();
        c      = cyc;
        bus.in = raw;
        x      = raw ^ INVERT;
        r      = x & ~exp_out;
        f      = ~x & exp_out;
        t      = first_eval(c) + (N - 1) * RATE;
        if ((r | f) != 4'b0) push(r, f, 4'b0, x, t);
        if (r != 4'b0) push(4'b0, 4'b0, r, x, t + LONG_TICKS * RATE);
        exp_out = x;
        wait_until(t + LONG_TICKS * RATE + 2);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (exp_q.size() > 0) begin
                    mon_exp = exp_q[0];
                    if (int'(mon_exp[31:0]) >= cyc) break;
                    n_vec++;
                    n_err++;
                    $display("FAIL missing_event: expected rise=%b fall=%b long=%b out=%b at cycle %0d, none by %0d",
                             mon_exp[47:44], mon_exp[43:40], mon_exp[39:36], mon_exp[35:32],
                             mon_exp[31:0], cyc);
                    void'(exp_q.pop_front());
                end
                if ((bus.rise | bus.fall | bus.long_prs) != 4'b0) begin
                    mon_act = {bus.rise, bus.fall, bus.long_prs, bus.out, 32'(cyc)};
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_event: rise=%b fall=%b long=%b out=%b at cycle %0d, none expected",
                                 bus.rise, bus.fall, bus.long_prs, bus.out, cyc);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_act !== mon_exp) begin
                            n_err++;
                            $display("FAIL event: got rise=%b fall=%b long=%b out=%b cyc=%0d, expected rise=%b fall=%b long=%b out=%b cyc=%0d",
                                     mon_act[47:44], mon_act[43:40], mon_act[39:36], mon_act[35:32], mon_act[31:0],
                                     mon_exp[47:44], mon_exp[43:40], mon_exp[39:36], mon_exp[35:32], mon_exp[31:0]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int c;
        n_vec   = 0;
        n_err   = 0;
        exp_out = INIT_VAL;
        rst     = 1'b1;
        bus.in  = 4'b0000;

        // Reset held with inputs toggling: everything parked at reset values.
        repeat (6) begin
            @(negedge clk);
            bus.in = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        check("reset_out", bus.out, INIT_VAL);
        check("reset_rise", bus.rise, 4'b0);
        check("reset_fall", bus.fall, 4'b0);
        check("reset_long", bus.long_prs, 4'b0);
        check("reset_tick", bus.tick, 1'b0);
        bus.in = 4'b0000;
        rst    = 1'b0;
        // Channel 3 starts at 1, so its hold counter runs from the first tick.
        push(4'b0, 4'b0, 4'b1000, 4'b1000, (RATE + 1) + (LONG_TICKS - 1) * RATE);
        for (int i = 1; i <= 2 * RATE; i++) begin
            @(negedge clk);
            check("tick_phase", bus.tick, ((i % RATE) == 0) ? 1'b1 : 1'b0);
        end
        wait_until(24);

        // Clean press and release on channel 0.
        apply(4'b0001);
        check("press_out", bus.out, 4'b1001);
        apply(4'b0000);

        // Two-tick glitches on channel 1 separated by one agreeing tick.
        align();
        bus.in = 4'b0010;
        repeat (2 * RATE) @(negedge clk);
        bus.in = 4'b0000;
        repeat (RATE) @(negedge clk);
        bus.in = 4'b0010;
        repeat (2 * RATE) @(negedge clk);
        bus.in = 4'b0000;
        repeat (3 * RATE) @(negedge clk);
        check("glitch_out", bus.out, exp_out);

        // Long press on channel 2, held well past the threshold, then a second press.
        apply(4'b0100);
        repeat (20 * RATE) @(negedge clk);
        check("long_hold_out", bus.out, 4'b1100);
        apply(4'b0000);
        apply(4'b0100);
        apply(4'b0000);

        // Active-low channel 3: idle low input keeps out high, high input releases it.
        repeat (4 * RATE) @(negedge clk);
        check("active_low_idle", bus.out, 4'b1000);
        apply(4'b1000);
        check("active_low_out", bus.out, 4'b0000);
        apply(4'b0000);

        // Async reset while channels 0/1 sit at count 2 of 3 and channel 2 is high.
        apply(4'b0100);
        align();
        c      = cyc;
        bus.in = 4'b0111;
        wait_until(c + 2 * RATE + 1);
        check("queue_before_reset", exp_q.size(), 0);
        rst = 1'b1;
        #1;
        check("midreset_out", bus.out, INIT_VAL);
        check("midreset_rise", bus.rise, 4'b0);
        check("midreset_fall", bus.fall, 4'b0);
        check("midreset_long", bus.long_prs, 4'b0);
        @(negedge clk);
        rst     = 1'b0;
        exp_out = 4'b1111;
        push(4'b0111, 4'b0, 4'b0, 4'b1111, first_eval(0) + (N - 1) * RATE);
        push(4'b0, 4'b0, 4'b1000, 4'b1111, (RATE + 1) + (LONG_TICKS - 1) * RATE);
        push(4'b0, 4'b0, 4'b0111, 4'b1111, first_eval(0) + (N - 1 + LONG_TICKS) * RATE);
        wait_until(first_eval(0) + (N - 1 + LONG_TICKS) * RATE + 3);
        apply(4'b0000);

        repeat (4 * RATE) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
